// File: rtl/lagarto_l15_arb_pkg.sv
// Shared L1.5 channel encodings, request header layout and return routing
// for the Lagarto L1.5 request arbiter.
package lagarto_l15_arb_pkg;

  localparam logic [4:0] L15_LOAD_RQ  = 5'b00000;
  localparam logic [4:0] L15_STORE_RQ = 5'b00001;
  localparam logic [4:0] L15_AMO_RQ   = 5'b00110;
  localparam logic [4:0] L15_IMISS_RQ = 5'b10000;

  localparam logic [3:0] LOAD_RET   = 4'b0000;
  localparam logic [3:0] IFILL_RET  = 4'b0001;
  localparam logic [3:0] INV_RET    = 4'b0011;
  localparam logic [3:0] ST_ACK     = 4'b0100;
  localparam logic [3:0] ATOMIC_RET = 4'b1000;

  localparam logic TID_IC = 1'b0;
  localparam logic TID_DC = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

  // Width-independent part of a request; address and data widths are
  // parameters of the arbiter and are kept in separate registers.
  typedef struct packed {
    logic [4:0] rtype;
    logic       nc;
    logic [2:0] size;
    logic       tid;
  } l15_req_hdr_t;

  typedef struct packed {
    logic known;
    logic tid;
    logic dec;
  } rtrn_route_t;

  function automatic rtrn_route_t route_rtrn(input logic [3:0] rtype);
    rtrn_route_t r;
    r = '{known: 1'b1, tid: TID_DC, dec: 1'b1};
    case (rtype)
      IFILL_RET:                    r.tid = TID_IC;
      LOAD_RET, ST_ACK, ATOMIC_RET: r.dec = 1'b1;
      INV_RET:                      r.dec = 1'b0;  // unsolicited, nothing in flight
      default:                      r = '{known: 1'b0, tid: TID_IC, dec: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lagarto_l15_outstanding_cnt.sv
// Per-requester in-flight counter: saturates at 15, holds at 0 on a stray
// decrement and flags it through underflow_o.
module lagarto_l15_outstanding_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       underflow_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + 4'd1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lagarto_l15_req_arbiter.sv
// Round-robin arbiter of I-cache and D-cache requests onto the single L1.5
// channel, with per-requester outstanding tracking and return routing.
module lagarto_l15_req_arbiter
  import lagarto_l15_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 40,
  parameter int unsigned DataWidth      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_req_val_i,
  output logic                 ic_req_rdy_o,
  input  logic [4:0]           ic_req_type_i,
  input  logic [AddrWidth-1:0] ic_req_addr_i,
  input  logic                 ic_req_nc_i,
  input  logic [2:0]           ic_req_size_i,
  input  logic                 dc_req_val_i,
  output logic                 dc_req_rdy_o,
  input  logic [4:0]           dc_req_type_i,
  input  logic [AddrWidth-1:0] dc_req_addr_i,
  input  logic                 dc_req_nc_i,
  input  logic [2:0]           dc_req_size_i,
  input  logic [DataWidth-1:0] dc_req_data_i,
  output logic                 l15_req_val_o,
  input  logic                 l15_req_ack_i,
  output logic [4:0]           l15_req_type_o,
  output logic [AddrWidth-1:0] l15_req_addr_o,
  output logic                 l15_req_nc_o,
  output logic [2:0]           l15_req_size_o,
  output logic [DataWidth-1:0] l15_req_data_o,
  output logic                 l15_req_tid_o,
  input  logic                 l15_rtrn_val_i,
  input  logic [3:0]           l15_rtrn_type_i,
  input  logic                 l15_rtrn_tid_i,
  output logic                 l15_rtrn_ack_o,
  output logic                 ic_rtrn_val_o,
  input  logic                 ic_rtrn_rdy_i,
  output logic                 dc_rtrn_val_o,
  input  logic                 dc_rtrn_rdy_i,
  output logic [3:0]           ic_outstanding_o,
  output logic [3:0]           dc_outstanding_o,
  output logic                 err_o
);

  arb_state_e           state_q, state_d;
  l15_req_hdr_t         hdr_q, hdr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 rr_q, rr_d;
  logic                 err_q, err_d;

  logic [3:0]  ic_cnt, dc_cnt;
  logic        ic_uf, dc_uf;
  logic        ic_elig, dc_elig, grant_dc, req_hs;
  logic        ic_inc, dc_inc, ic_dec, dc_dec;
  rtrn_route_t rroute;

  assign ic_elig  = ic_req_val_i && (32'(ic_cnt) < MaxOutstanding);
  assign dc_elig  = dc_req_val_i && (32'(dc_cnt) < MaxOutstanding);
  // rr_q holds the tid that wins when both requesters are eligible
  assign grant_dc = dc_elig && (!ic_elig || rr_q == TID_DC);
  assign req_hs   = (state_q == ARB_HOLD) && l15_req_ack_i;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (ic_elig || dc_elig) begin
          state_d = ARB_HOLD;
          if (grant_dc) begin
            hdr_d  = '{rtype: dc_req_type_i, nc: dc_req_nc_i, size: dc_req_size_i, tid: TID_DC};
            addr_d = dc_req_addr_i;
            data_d = dc_req_data_i;
          end else begin
            hdr_d  = '{rtype: ic_req_type_i, nc: ic_req_nc_i, size: ic_req_size_i, tid: TID_IC};
            addr_d = ic_req_addr_i;
            data_d = '0;
          end
        end
      end
      ARB_HOLD: begin
        if (l15_req_ack_i) begin
          state_d = ARB_IDLE;
          rr_d    = ~hdr_q.tid;
        end
      end
    endcase
  end

  always_comb begin
    rroute         = route_rtrn(l15_rtrn_type_i);
    ic_rtrn_val_o  = l15_rtrn_val_i && rroute.known && (rroute.tid == TID_IC);
    dc_rtrn_val_o  = l15_rtrn_val_i && rroute.known && (rroute.tid == TID_DC);
    // unknown return types are swallowed so the channel never stalls on them
    l15_rtrn_ack_o = l15_rtrn_val_i &&
                     (!rroute.known || ((rroute.tid == TID_IC) ? ic_rtrn_rdy_i : dc_rtrn_rdy_i));
    ic_dec = l15_rtrn_ack_o && rroute.known && rroute.dec && (rroute.tid == TID_IC);
    dc_dec = l15_rtrn_ack_o && rroute.known && rroute.dec && (rroute.tid == TID_DC);
    err_d  = err_q || ic_uf || dc_uf ||
             (l15_rtrn_val_i && (!rroute.known || (l15_rtrn_tid_i != rroute.tid)));
  end

  assign ic_inc = req_hs && (hdr_q.tid == TID_IC);
  assign dc_inc = req_hs && (hdr_q.tid == TID_DC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      hdr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rr_q    <= TID_IC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  lagarto_l15_outstanding_cnt u_ic_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (ic_inc),
    .dec_i       (ic_dec),
    .cnt_o       (ic_cnt),
    .underflow_o (ic_uf)
  );

  lagarto_l15_outstanding_cnt u_dc_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (dc_inc),
    .dec_i       (dc_dec),
    .cnt_o       (dc_cnt),
    .underflow_o (dc_uf)
  );

  assign ic_req_rdy_o     = ic_inc;
  assign dc_req_rdy_o     = dc_inc;
  assign l15_req_val_o    = (state_q == ARB_HOLD);
  assign l15_req_type_o   = hdr_q.rtype;
  assign l15_req_addr_o   = addr_q;
  assign l15_req_nc_o     = hdr_q.nc;
  assign l15_req_size_o   = hdr_q.size;
  assign l15_req_data_o   = data_q;
  assign l15_req_tid_o    = hdr_q.tid;
  assign ic_outstanding_o = ic_cnt;
  assign dc_outstanding_o = dc_cnt;
  assign err_o            = err_q;

endmodule

// File: tb/tb_lagarto_l15_req_arbiter.sv
// Scoreboard bench for lagarto_l15_req_arbiter: issued requests are queued
// per requester and checked by a negedge monitor against a behavioural model.
module tb_lagarto_l15_req_arbiter;

  localparam int unsigned MAXO = 4;
  localparam logic [3:0] T_LOAD = 4'b0000, T_IFILL = 4'b0001, T_INV = 4'b0011,
                         T_ST = 4'b0100, T_ATOM = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        ic_req_val_i, ic_req_rdy_o, ic_req_nc_i;
  logic [4:0]  ic_req_type_i;
  logic [39:0] ic_req_addr_i;
  logic [2:0]  ic_req_size_i;
  logic        dc_req_val_i, dc_req_rdy_o, dc_req_nc_i;
  logic [4:0]  dc_req_type_i;
  logic [39:0] dc_req_addr_i;
  logic [2:0]  dc_req_size_i;
  logic [63:0] dc_req_data_i;
  logic        l15_req_val_o, l15_req_ack_i, l15_req_nc_o, l15_req_tid_o;
  logic [4:0]  l15_req_type_o;
  logic [39:0] l15_req_addr_o;
  logic [2:0]  l15_req_size_o;
  logic [63:0] l15_req_data_o;
  logic        l15_rtrn_val_i, l15_rtrn_tid_i, l15_rtrn_ack_o;
  logic [3:0]  l15_rtrn_type_i;
  logic        ic_rtrn_val_o, ic_rtrn_rdy_i, dc_rtrn_val_o, dc_rtrn_rdy_i;
  logic [3:0]  ic_outstanding_o, dc_outstanding_o;
  logic        err_o;

  lagarto_l15_req_arbiter #(.MaxOutstanding(MAXO), .AddrWidth(40), .DataWidth(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_val_i(ic_req_val_i), .ic_req_rdy_o(ic_req_rdy_o), .ic_req_type_i(ic_req_type_i),
    .ic_req_addr_i(ic_req_addr_i), .ic_req_nc_i(ic_req_nc_i), .ic_req_size_i(ic_req_size_i),
    .dc_req_val_i(dc_req_val_i), .dc_req_rdy_o(dc_req_rdy_o), .dc_req_type_i(dc_req_type_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_nc_i(dc_req_nc_i), .dc_req_size_i(dc_req_size_i),
    .dc_req_data_i(dc_req_data_i),
    .l15_req_val_o(l15_req_val_o), .l15_req_ack_i(l15_req_ack_i), .l15_req_type_o(l15_req_type_o),
    .l15_req_addr_o(l15_req_addr_o), .l15_req_nc_o(l15_req_nc_o), .l15_req_size_o(l15_req_size_o),
    .l15_req_data_o(l15_req_data_o), .l15_req_tid_o(l15_req_tid_o),
    .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_type_i(l15_rtrn_type_i), .l15_rtrn_tid_i(l15_rtrn_tid_i),
    .l15_rtrn_ack_o(l15_rtrn_ack_o),
    .ic_rtrn_val_o(ic_rtrn_val_o), .ic_rtrn_rdy_i(ic_rtrn_rdy_i),
    .dc_rtrn_val_o(dc_rtrn_val_o), .dc_rtrn_rdy_i(dc_rtrn_rdy_i),
    .ic_outstanding_o(ic_outstanding_o), .dc_outstanding_o(dc_outstanding_o), .err_o(err_o)
  );

  typedef logic [112:0] req_vec_t;  // {type, addr, nc, size, data}
  req_vec_t exp_ic[$];
  req_vec_t exp_dc[$];
  int       grant_log[$];
  int       checks = 0, errors = 0;
  int       mcnt[2];
  logic     merr;

  int   want_ic, want_dc, ack_mode, rt_mode;
  logic hs_ic, hs_dc, hs_rt;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int grants_of(int tid);
    int n = 0;
    foreach (grant_log[i]) if (grant_log[i] == tid) n++;
    return n;
  endfunction

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : mon
    req_vec_t cur;
    logic hs, bad, dec_ok, rv, e_ack;
    int   t, dest;
    cur = {l15_req_type_o, l15_req_addr_o, l15_req_nc_o, l15_req_size_o, l15_req_data_o};
    t   = int'(l15_req_tid_o);
    hs  = l15_req_val_o && l15_req_ack_i;

    chk("ic_outstanding", ic_outstanding_o, mcnt[0]);
    chk("dc_outstanding", dc_outstanding_o, mcnt[1]);
    chk("err", err_o, merr);
    chk("ic_req_rdy", ic_req_rdy_o, hs && t == 0);
    chk("dc_req_rdy", dc_req_rdy_o, hs && t == 1);

    if (l15_req_val_o && !rst_i) begin
      if ((t == 0) ? (exp_ic.size() == 0) : (exp_dc.size() == 0)) begin
        checks++; errors++;
        $display("FAIL req_owner: grant to tid %0d with no pending request", t);
      end else begin
        chk("req_fields", cur, (t == 0) ? exp_ic[0] : exp_dc[0]);
        if (hs) begin
          if (t == 0) void'(exp_ic.pop_front());
          else        void'(exp_dc.pop_front());
          grant_log.push_back(t);
        end
      end
    end

    bad = 1'b0; dest = 1; dec_ok = 1'b1;
    case (l15_rtrn_type_i)
      T_IFILL:               dest = 0;
      T_LOAD, T_ST, T_ATOM:  dest = 1;
      T_INV:                 dec_ok = 1'b0;
      default: begin bad = 1'b1; dec_ok = 1'b0; end
    endcase
    rv    = l15_rtrn_val_i;
    e_ack = rv && (bad || ((dest == 0) ? ic_rtrn_rdy_i : dc_rtrn_rdy_i));
    chk("ic_rtrn_val", ic_rtrn_val_o, rv && !bad && dest == 0);
    chk("dc_rtrn_val", dc_rtrn_val_o, rv && !bad && dest == 1);
    chk("rtrn_ack", l15_rtrn_ack_o, e_ack);

    if (rst_i) begin
      mcnt[0] = 0; mcnt[1] = 0; merr = 1'b0;
      exp_ic.delete(); exp_dc.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic inc, dec;
        inc = hs && t == k;
        dec = e_ack && dec_ok && dest == k;
        if (inc && !dec && mcnt[k] < 15) mcnt[k]++;
        else if (dec && !inc) begin
          if (mcnt[k] == 0) merr = 1'b1;
          else              mcnt[k]--;
        end
      end
      if (rv && (bad || int'(l15_rtrn_tid_i) != dest)) merr = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_ic();
    ic_req_val_i  = 1'b1;
    ic_req_type_i = 5'($urandom);
    ic_req_addr_i = 40'({$urandom, $urandom});
    ic_req_nc_i   = 1'($urandom);
    ic_req_size_i = 3'($urandom);
    exp_ic.push_back({ic_req_type_i, ic_req_addr_i, ic_req_nc_i, ic_req_size_i, 64'd0});
  endtask

  task automatic issue_dc();
    dc_req_val_i  = 1'b1;
    dc_req_type_i = 5'($urandom);
    dc_req_addr_i = 40'({$urandom, $urandom});
    dc_req_nc_i   = 1'($urandom);
    dc_req_size_i = 3'($urandom);
    dc_req_data_i = {$urandom, $urandom};
    exp_dc.push_back({dc_req_type_i, dc_req_addr_i, dc_req_nc_i, dc_req_size_i, dc_req_data_i});
  endtask

  // One clock: observe handshakes at negedge, then drive new inputs 1 after posedge.
  task automatic cycle();
    @(negedge clk);
    hs_ic = ic_req_rdy_o;
    hs_dc = dc_req_rdy_o;
    hs_rt = l15_rtrn_ack_o;
    @(posedge clk);
    #1;
    if (ic_req_val_i && hs_ic) ic_req_val_i = 1'b0;
    if (dc_req_val_i && hs_dc) dc_req_val_i = 1'b0;
    if (!ic_req_val_i && (want_ic == 1 || (want_ic == 2 && $urandom_range(0, 1) == 1))) issue_ic();
    if (!dc_req_val_i && (want_dc == 1 || (want_dc == 2 && $urandom_range(0, 1) == 1))) issue_dc();
    case (ack_mode)
      1:       l15_req_ack_i = l15_req_val_o;
      2:       l15_req_ack_i = l15_req_val_o && ($urandom_range(0, 1) == 1);
      default: l15_req_ack_i = 1'b0;
    endcase
    if (rt_mode == 1) begin
      if (l15_rtrn_val_i && hs_rt) l15_rtrn_val_i = 1'b0;
      ic_rtrn_rdy_i = ($urandom_range(0, 3) != 0);
      dc_rtrn_rdy_i = ($urandom_range(0, 3) != 0);
      if (!l15_rtrn_val_i && $urandom_range(0, 1) == 1) begin
        if (mcnt[0] > 0 && $urandom_range(0, 1) == 1) begin
          l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = T_IFILL; l15_rtrn_tid_i = 1'b0;
        end else if (mcnt[1] > 0) begin
          l15_rtrn_val_i = 1'b1; l15_rtrn_tid_i = 1'b1;
          case ($urandom_range(0, 2))
            0:       l15_rtrn_type_i = T_LOAD;
            1:       l15_rtrn_type_i = T_ST;
            default: l15_rtrn_type_i = T_ATOM;
          endcase
        end else if ($urandom_range(0, 7) == 0) begin
          l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = T_INV; l15_rtrn_tid_i = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    want_ic = 0; want_dc = 0; ack_mode = 0; rt_mode = 0;
    ic_req_val_i = 1'b0; dc_req_val_i = 1'b0;
    l15_req_ack_i = 1'b0; l15_rtrn_val_i = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic send_rtrn(input logic [3:0] ty, input logic tid);
    l15_rtrn_val_i = 1'b1; l15_rtrn_type_i = ty; l15_rtrn_tid_i = tid;
  endtask

  initial begin
    rst_i = 1'b1;
    ic_req_val_i = 0; ic_req_type_i = '0; ic_req_addr_i = '0; ic_req_nc_i = 0; ic_req_size_i = '0;
    dc_req_val_i = 0; dc_req_type_i = '0; dc_req_addr_i = '0; dc_req_nc_i = 0; dc_req_size_i = '0;
    dc_req_data_i = '0; l15_req_ack_i = 0;
    l15_rtrn_val_i = 0; l15_rtrn_type_i = '0; l15_rtrn_tid_i = 0;
    ic_rtrn_rdy_i = 0; dc_rtrn_rdy_i = 0;
    mcnt[0] = 0; mcnt[1] = 0; merr = 1'b0;
    hs_ic = 0; hs_dc = 0; hs_rt = 0;

    // reset state
    do_reset();
    #1;
    chk("rst_val", l15_req_val_o, 1'b0);
    chk("rst_type", l15_req_type_o, 5'd0);
    chk("rst_addr", l15_req_addr_o, 40'd0);
    chk("rst_tid", l15_req_tid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_cnt", {ic_outstanding_o, dc_outstanding_o}, 8'd0);

    // single I-cache request acked on its third valid cycle
    want_ic = 1; cycle(); want_ic = 0;
    cycle(); #1 chk("single_val_c1", l15_req_val_o, 1'b1);
    cycle(); #1 chk("single_val_c2", l15_req_val_o, 1'b1);
    cycle(); l15_req_ack_i = 1'b1;
    #1 chk("single_val_c3", l15_req_val_o, 1'b1);
    chk("single_ic_rdy", ic_req_rdy_o, 1'b1);
    cycle(); #1 chk("single_val_after", l15_req_val_o, 1'b0);
    chk("single_ic_cnt1", ic_outstanding_o, 4'd1);
    ic_rtrn_rdy_i = 1'b1; send_rtrn(T_IFILL, 1'b0);
    #1 chk("ifill_ack", l15_rtrn_ack_o, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("ifill_cnt0", ic_outstanding_o, 4'd0);

    // round-robin alternation starting from the I-cache
    do_reset(); grant_log.delete();
    want_ic = 1; want_dc = 1; ack_mode = 1;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) cycle();
    want_ic = 0; want_dc = 0;
    for (int i = 0; i < 20 && (ic_req_val_i || dc_req_val_i); i++) cycle();
    chk("rr_grant_count", grant_log.size() >= 4, 1'b1);
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("rr_order", grant_log[i], i % 2);

    // outstanding budget blocks the D-cache only
    do_reset(); grant_log.delete();
    want_dc = 1; ack_mode = 1;
    repeat (30) cycle();
    want_dc = 0;
    chk("budget_dc_grants", grants_of(1), MAXO);
    chk("budget_dc_cnt", dc_outstanding_o, 4'(MAXO));
    want_ic = 1; cycle(); want_ic = 0;
    repeat (8) cycle();
    chk("budget_ic_granted", grants_of(0), 1);
    chk("budget_dc_still", grants_of(1), MAXO);
    dc_rtrn_rdy_i = 1'b1; send_rtrn(T_ST, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    repeat (8) cycle();
    chk("budget_dc_fifth", grants_of(1), MAXO + 1);

    // return back-pressure on the D-cache side
    dc_rtrn_rdy_i = 1'b0; send_rtrn(T_LOAD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_dc_val", dc_rtrn_val_o, 1'b1);
      chk("bp_ack_low", l15_rtrn_ack_o, 1'b0);
      cycle();
    end
    dc_rtrn_rdy_i = 1'b1;
    #1 chk("bp_ack_high", l15_rtrn_ack_o, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("bp_dc_cnt", dc_outstanding_o, 4'd3);

    // simultaneous increment and decrement, then INV_RET at zero
    do_reset(); grant_log.delete();
    want_dc = 1; ack_mode = 1;
    for (int i = 0; i < 20 && grant_log.size() < 2; i++) cycle();
    want_dc = 0; ack_mode = 0;
    for (int i = 0; i < 10 && !l15_req_val_o; i++) cycle();
    chk("wait_req_val", l15_req_val_o, 1'b1);
    l15_req_ack_i = 1'b1; dc_rtrn_rdy_i = 1'b1; send_rtrn(T_LOAD, 1'b1);
    #1 chk("same_pre_cnt", dc_outstanding_o, 4'd2);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("same_post_cnt", dc_outstanding_o, 4'd2);
    send_rtrn(T_LOAD, 1'b1);
    cycle(); cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("drain_cnt0", dc_outstanding_o, 4'd0);
    send_rtrn(T_INV, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("inv_cnt0", dc_outstanding_o, 4'd0);
    chk("inv_no_err", err_o, 1'b0);

    // unknown return type
    send_rtrn(4'b1111, 1'b0);
    #1 chk("bad_type_ack", l15_rtrn_ack_o, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("bad_type_err", err_o, 1'b1);

    // underflow
    do_reset();
    #1 chk("err_cleared", err_o, 1'b0);
    send_rtrn(T_LOAD, 1'b1);
    cycle(); l15_rtrn_val_i = 1'b0;
    #1 chk("underflow_err", err_o, 1'b1);
    chk("underflow_cnt", dc_outstanding_o, 4'd0);

    // reset while holding a request
    want_dc = 1; ack_mode = 1; cycle(); want_dc = 0;
    for (int i = 0; i < 10 && dc_outstanding_o == 4'd0; i++) cycle();
    ack_mode = 0;
    want_ic = 1; cycle(); want_ic = 0;
    for (int i = 0; i < 10 && !l15_req_val_o; i++) cycle();
    chk("hold_reached", l15_req_val_o, 1'b1);
    rst_i = 1'b1; ic_req_val_i = 1'b0;
    cycle(); rst_i = 1'b0;
    #1 chk("rst_hold_val", l15_req_val_o, 1'b0);
    chk("rst_hold_err", err_o, 1'b0);
    chk("rst_hold_cnt", {ic_outstanding_o, dc_outstanding_o}, 8'd0);

    // randomized traffic against the model
    do_reset();
    want_ic = 2; want_dc = 2; ack_mode = 2; rt_mode = 1;
    repeat (800) cycle();
    want_ic = 0; want_dc = 0; ack_mode = 1;
    repeat (40) cycle();
    rt_mode = 0; l15_rtrn_val_i = 1'b0;
    cycle();
    #1 chk("random_err", err_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
